sp_ram_be: RTL

- Parametrised single-port synchronous RAM with byte write enables, a selectable read-during-write mode and an optional output register stage.
- Data-path `rd_valid` handshake on reads.
- A built-in clear sequencer zeroes every location after reset.
- General storage primitive for FIFOs, buffers and register files across the design.

---
 rtl/sp_ram_be.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sp_ram_be.sv
// sp_ram_be: single-port RAM with byte write enables, a post-reset clear sequencer, selectable
// read-during-write behaviour and optional output register. Parity lanes: SP_RAM_BE_PARITY_EN.
module sp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            data_in,
`ifdef SP_RAM_BE_PARITY_EN
  input  logic                             par_inject,
  output logic                             parity_err,
`endif
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             rd_valid,
  output logic                             ready
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  clr_cnt;
  logic                   ready_q;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];

  logic                   accept, acc_wr, acc_rd, clearing;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [NB-1:0]          wr_lanes;
  logic [DATA_WIDTH-1:0]  wr_data, old_word, merged;

  logic [DATA_WIDTH-1:0]  s1_data;
  logic                   s1_valid;

  // An access in the same cycle as reset must not touch memory or the read pipeline.
  assign accept   = en & ready_q & ~rst;
  assign acc_wr   = accept & we;
  assign acc_rd   = accept & ~we;
  assign clearing = (state == CLEAR) & ~rst;
  assign old_word = mem[addr];

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    wr_addr  = clearing ? clr_cnt : addr;
    wr_data  = clearing ? '0 : data_in;
    wr_lanes = clearing ? '1 : (acc_wr ? be : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lanes[i]) mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Stage 1 carries read data, or the read-during-write view of a write; idle cycles hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= acc_rd;
      if (acc_rd) begin
        s1_data <= old_word;
      end else if (acc_wr) begin
        if (RDW_MODE == 0)      s1_data <= old_word;
        else if (RDW_MODE == 1) s1_data <= merged;
      end
    end
  end

`ifdef SP_RAM_BE_PARITY_EN
  function automatic logic [NB-1:0] lane_parity(input logic [DATA_WIDTH-1:0] w);
    logic [NB-1:0] res;
    res = '0;
    for (int i = 0; i < NB; i++) res[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
    return res;
  endfunction

  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;
  logic          rd_perr, s1_perr;

  assign wr_par  = clearing ? '0 : (lane_parity(data_in) ^ {NB{par_inject}});
  assign rd_perr = |(par_mem[addr] ^ lane_parity(old_word));

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_lanes[i]) par_mem[wr_addr][i] <= wr_par[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_perr <= 1'b0;
    else     s1_perr <= acc_rd & rd_perr;
  end
`endif

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign data_out = s2_data;
      assign rd_valid = s2_valid;
`ifdef SP_RAM_BE_PARITY_EN
      logic s2_perr;
      always_ff @(posedge clk) begin
        if (rst) s2_perr <= 1'b0;
        else     s2_perr <= s1_perr;
      end
      assign parity_err = s2_perr;
`endif
    end else begin : g_out_direct
      assign data_out = s1_data;
      assign rd_valid = s1_valid;
`ifdef SP_RAM_BE_PARITY_EN
      assign parity_err = s1_perr;
`endif
    end
  endgenerate

  assign ready = ready_q;

endmodule
